// File: rtl/qrs_pkg.sv
// Shared types and defaults for the QRS detector chain, plus the sign-strip
// magnitude rule used by both the max calculator and the peak detector.
package qrs_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_REFRACT
    } qrs_state_t;

    localparam int FS_HZ         = 360;
    localparam int REFRACT_DEF   = 72;
    localparam int MAX_TRACK_DEF = 54;
    localparam int ABS_W         = 64;

    // The sign bit is dropped, not negated, so |x| is only approximate for negatives.
    function automatic logic [ABS_W-1:0] abs_mag(input logic [ABS_W-1:0] dn, input int w);
        logic [ABS_W-1:0] keep;
        keep = ~(ABS_W'(1) << (w - 1));
        return dn & keep;
    endfunction

endpackage

// File: rtl/qrs_peak_detect_if.sv
// Sample/threshold inputs and peak/RR outputs of qrs_peak_detect.
// The rr_avg signal exists only when QRS_RR_AVG_EN is defined.
interface qrs_peak_detect_if #(
    parameter int DATA_W = 32,
    parameter int RR_W   = 16
);
    logic signed [DATA_W-1:0] dn;
    logic                     ds;
    logic        [DATA_W-1:0] threshold;
    logic                     dc;
    logic                     peak_vld;
    logic        [DATA_W-1:0] peak_val;
    logic        [RR_W-1:0]   rr_out;
    logic                     rr_vld;
`ifdef QRS_RR_AVG_EN
    logic        [RR_W-1:0]   rr_avg;

    modport master (
        output dn, ds, threshold,
        input  dc, peak_vld, peak_val, rr_out, rr_vld, rr_avg
    );
    modport slave (
        input  dn, ds, threshold,
        output dc, peak_vld, peak_val, rr_out, rr_vld, rr_avg
    );
`else
    modport master (
        output dn, ds, threshold,
        input  dc, peak_vld, peak_val, rr_out, rr_vld
    );
    modport slave (
        input  dn, ds, threshold,
        output dc, peak_vld, peak_val, rr_out, rr_vld
    );
`endif
endinterface

// File: rtl/qrs_rr_avg.sv
// Mean of the last eight RR intervals: 8-entry shift register with a running sum.
module qrs_rr_avg #(
    parameter int RR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rr_new_i,
    input  logic [RR_W-1:0] rr_i,
    output logic [RR_W-1:0] rr_avg_o
);
    localparam int SUM_W = RR_W + 3;

    logic [RR_W-1:0]  taps_q [8];
    logic [RR_W-1:0]  taps_d [8];
    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        taps_d = taps_q;
        sum_d  = sum_q;
        if (rr_new_i) begin
            // Entry 7 leaves the window as the new interval enters, so the sum never rescans.
            sum_d     = sum_q + SUM_W'(rr_i) - SUM_W'(taps_q[7]);
            taps_d[0] = rr_i;
            for (int i = 1; i < 8; i++) begin
                taps_d[i] = taps_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            for (int i = 0; i < 8; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            sum_q  <= sum_d;
            taps_q <= taps_d;
        end
    end

    assign rr_avg_o = sum_q[SUM_W-1:3];

endmodule

// File: rtl/qrs_peak_detect.sv
// R-peak detector: tracks samples above 0.75x the running max, emits peak and RR
// interval, and holds the max calculator during refractory. QRS_RR_AVG_EN adds rr_avg.
module qrs_peak_detect
    import qrs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RR_W      = 16,
    parameter int REFRACT   = REFRACT_DEF,
    parameter int MAX_TRACK = MAX_TRACK_DEF
) (
    input logic              clk,
    input logic              rst,
    qrs_peak_detect_if.slave bus
);
    localparam int TRK_W = $clog2(MAX_TRACK + 1);
    localparam int REF_W = $clog2(REFRACT + 1);
    localparam logic [RR_W-1:0]  RR_MAX    = '1;
    localparam logic [TRK_W-1:0] TRK_LIMIT = TRK_W'(MAX_TRACK);
    localparam logic [REF_W-1:0] REF_LOAD  = REF_W'(REFRACT);

    qrs_state_t        state_q, state_d;
    logic [RR_W-1:0]   rr_cnt_q, rr_cnt_d;
    logic [TRK_W-1:0]  trk_cnt_q, trk_cnt_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              first_q, first_d;
    logic              dc_q, dc_d;
    logic              peak_vld_q, peak_vld_d;
    logic [DATA_W-1:0] peak_val_q, peak_val_d;
    logic [RR_W-1:0]   rr_out_q, rr_out_d;
    logic              rr_vld_q, rr_vld_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [RR_W-1:0]   rr_cap_q, rr_cap_d;

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] thr_eff;
    logic [RR_W-1:0]   rr_inc;
    logic [DATA_W-1:0] cand_upd;
    logic [RR_W-1:0]   cap_upd;
    logic              below;
`ifdef QRS_RR_AVG_EN
    logic              rr_new_q, rr_new_d;
`endif

    assign mag     = DATA_W'(abs_mag(ABS_W'($unsigned(bus.dn)), DATA_W));
    assign thr_eff = bus.threshold - (bus.threshold >> 2);
    assign rr_inc  = (rr_cnt_q == RR_MAX) ? rr_cnt_q : rr_cnt_q + RR_W'(1);

    always_comb begin
        state_d    = state_q;
        rr_cnt_d   = rr_cnt_q;
        trk_cnt_d  = trk_cnt_q;
        ref_cnt_d  = ref_cnt_q;
        first_d    = first_q;
        dc_d       = dc_q;
        peak_vld_d = 1'b0;
        peak_val_d = peak_val_q;
        rr_out_d   = rr_out_q;
        rr_vld_d   = rr_vld_q;
        cand_d     = cand_q;
        rr_cap_d   = rr_cap_q;
        cand_upd   = cand_q;
        cap_upd    = rr_cap_q;
        below      = 1'b0;
`ifdef QRS_RR_AVG_EN
        rr_new_d   = 1'b0;
`endif
        if (bus.ds) begin
            rr_cnt_d = rr_inc;
            unique case (state_q)
                ST_SEARCH: begin
                    if (thr_eff != '0 && mag > thr_eff) begin
                        state_d   = ST_TRACK;
                        cand_d    = mag;
                        rr_cap_d  = rr_cnt_q;
                        trk_cnt_d = TRK_W'(1);
                    end
                end
                ST_TRACK: begin
                    below = mag < thr_eff;
                    // >= lets a plateau move the peak position to its last sample.
                    if (!below && mag >= cand_q) begin
                        cand_upd = mag;
                        cap_upd  = rr_cnt_q;
                    end
                    cand_d    = cand_upd;
                    rr_cap_d  = cap_upd;
                    trk_cnt_d = trk_cnt_q + TRK_W'(1);
                    if (below || trk_cnt_d >= TRK_LIMIT) begin
                        peak_vld_d = 1'b1;
                        peak_val_d = cand_upd;
                        if (first_q) begin
                            first_d = 1'b0;
                        end else begin
                            rr_out_d = cap_upd;
                            rr_vld_d = 1'b1;
`ifdef QRS_RR_AVG_EN
                            rr_new_d = 1'b1;
`endif
                        end
                        // Restart the interval count from the peak, not from the emit point.
                        rr_cnt_d  = rr_inc - cap_upd;
                        state_d   = ST_REFRACT;
                        ref_cnt_d = REF_LOAD;
                        dc_d      = 1'b1;
                    end
                end
                ST_REFRACT: begin
                    ref_cnt_d = ref_cnt_q - REF_W'(1);
                    if (ref_cnt_q <= REF_W'(1)) begin
                        ref_cnt_d = '0;
                        state_d   = ST_SEARCH;
                        dc_d      = 1'b0;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            rr_cnt_q   <= '0;
            trk_cnt_q  <= '0;
            ref_cnt_q  <= '0;
            first_q    <= 1'b1;
            dc_q       <= 1'b0;
            peak_vld_q <= 1'b0;
            peak_val_q <= '0;
            rr_out_q   <= '0;
            rr_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_cnt_q   <= rr_cnt_d;
            trk_cnt_q  <= trk_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            first_q    <= first_d;
            dc_q       <= dc_d;
            peak_vld_q <= peak_vld_d;
            peak_val_q <= peak_val_d;
            rr_out_q   <= rr_out_d;
            rr_vld_q   <= rr_vld_d;
        end
    end

    // Candidate value/position are only read in TRACK, which always loads them first.
    always_ff @(posedge clk) begin
        cand_q   <= cand_d;
        rr_cap_q <= rr_cap_d;
    end

    assign bus.dc       = dc_q;
    assign bus.peak_vld = peak_vld_q;
    assign bus.peak_val = peak_val_q;
    assign bus.rr_out   = rr_out_q;
    assign bus.rr_vld   = rr_vld_q;

`ifdef QRS_RR_AVG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_new_q <= 1'b0;
        end else begin
            rr_new_q <= rr_new_d;
        end
    end

    qrs_rr_avg #(
        .RR_W (RR_W)
    ) u_rr_avg (
        .clk      (clk),
        .rst      (rst),
        .rr_new_i (rr_new_q),
        .rr_i     (rr_out_q),
        .rr_avg_o (bus.rr_avg)
    );
`endif

endmodule
